// File: rtl/run_ctrl.sv
// run_ctrl - host-side run sequencer for the basic processor.
//
// On a go request it pulses the processor start line, counts cycles until
// the processor raises halt, then streams a block of data memory out
// through a valid/ready result port and reports the run cycle count.
//
// Optional feature macro: RUN_CTRL_TIMEOUT_EN
//   defined   - RUN is bounded by a watchdog of TIMEOUT cycles; on expiry
//               the timeout flag is set and readback still happens.
//   undefined - RUN waits for halt indefinitely; timeout is tied low and
//               the TIMEOUT parameter has no effect.
//
// Parameters:
//   AW           data-memory address width
//   DW           data-memory word width
//   START_CYCLES length of the dut_start pulse (>= 1)
//   TIMEOUT      RUN cycles allowed before the watchdog fires
//
// Ports:
//   CLK        clock, rising edge
//   reset      synchronous active-high reset
//   go         run request, only honoured in IDLE
//   rd_base    first readback address, captured on go
//   rd_len     readback word count (0..2^AW), captured on go
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of a run
//   timeout    sticky watchdog flag for the last run
//   cycles     saturating cycle count of the last run
//   dut_start  processor start line
//   dut_halt   processor halt line
//   mem_own    high while this block drives the data-memory address
//   mem_addr   data-memory address (rd_base + index, wraps mod 2^AW)
//   mem_rdata  data-memory read data, combinational on mem_addr
//   res_valid  readback word available
//   res_ready  consumer accepts the word
//   res_data   readback word (mem_rdata passed straight through)
module run_ctrl #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 8,
  parameter int unsigned START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'd50000
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          go,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_len,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [15:0]   cycles,
  output logic          dut_start,
  input  logic          dut_halt,
  output logic          mem_own,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] base_q;
  logic [AW-1:0] base_next;
  logic [AW:0]   len_q;
  logic [AW:0]   len_next;
  logic [AW:0]   idx_q;
  logic [AW:0]   idx_next;
  logic [15:0]   start_cnt;
  logic [15:0]   start_cnt_next;
  logic [15:0]   cycles_next;
  logic          timeout_next;
  logic [AW-1:0] addr_next;

`ifdef RUN_CTRL_TIMEOUT_EN
  // One bit wider than the count so the comparison cannot wrap.
  logic [16:0]   count_inc;
`else
  // Watchdog limit is meaningless without the watchdog.
  if (TIMEOUT == 16'd0) begin : g_timeout_unused
  end
`endif

  // Result word is the memory read data for the address currently driven.
  assign res_data = mem_rdata;

  always_comb begin
    state_next     = state;
    base_next      = base_q;
    len_next       = len_q;
    idx_next       = idx_q;
    start_cnt_next = start_cnt;
    cycles_next    = cycles;
    timeout_next   = timeout;
`ifdef RUN_CTRL_TIMEOUT_EN
    count_inc      = {1'b0, cycles} + 17'd1;
`else
    timeout_next   = 1'b0;
`endif

    unique case (state)
      S_IDLE: begin
        if (go) begin
          base_next      = rd_base;
          len_next       = rd_len;
          idx_next       = '0;
          start_cnt_next = '0;
          cycles_next    = '0;
          timeout_next   = 1'b0;
          state_next     = S_START;
        end
      end

      S_START: begin
        // Halt is deliberately not looked at while start is asserted.
        if (start_cnt == START_LAST) begin
          state_next = S_RUN;
        end else begin
          start_cnt_next = start_cnt + 16'd1;
        end
      end

      S_RUN: begin
        // cycles itself is the run counter: at RUN cycle N it holds N, so
        // seeing halt simply freezes it.
        if (dut_halt) begin
          idx_next   = '0;
          state_next = (len_q == '0) ? S_DONE : S_DRAIN;
        end
`ifdef RUN_CTRL_TIMEOUT_EN
        else if (count_inc >= {1'b0, TIMEOUT}) begin
          cycles_next  = TIMEOUT;
          timeout_next = 1'b1;
          idx_next     = '0;
          state_next   = (len_q == '0) ? S_DONE : S_DRAIN;
        end
`endif
        else if (cycles != '1) begin
          cycles_next = cycles + 16'd1;
        end
      end

      S_DRAIN: begin
        // res_valid is high for the whole of DRAIN, so ready alone is the
        // handshake.
        if (res_ready) begin
          if (idx_q + (AW+1)'(1) == len_q) begin
            state_next = S_DONE;
          end else begin
            idx_next = idx_q + (AW+1)'(1);
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Address is produced one cycle ahead so the registered value lines up
    // with the word being offered; it stays put while ready is low.
    addr_next = (state_next == S_DRAIN) ? (base_q + idx_next[AW-1:0]) : '0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      start_cnt <= '0;
      cycles    <= '0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_start <= 1'b0;
      mem_own   <= 1'b0;
      mem_addr  <= '0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_next;
      base_q    <= base_next;
      len_q     <= len_next;
      idx_q     <= idx_next;
      start_cnt <= start_cnt_next;
      cycles    <= cycles_next;
      timeout   <= timeout_next;
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
      dut_start <= (state_next == S_START);
      mem_own   <= (state_next == S_DRAIN);
      mem_addr  <= addr_next;
      res_valid <= (state_next == S_DRAIN);
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl: table of directed runs, hand-written corner
// sequences (reset mid-readback, go held through a run) and randomized runs
// checked against a simple behavioural model of the run sequence.
module tb_run_ctrl;

  localparam int          SC         = 2;
  localparam logic [15:0] TB_TIMEOUT = 16'd100;
`ifdef RUN_CTRL_TIMEOUT_EN
  localparam bit          TO_EN      = 1'b1;
`else
  localparam bit          TO_EN      = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  rd_base = '0;
  logic [8:0]  rd_len = '0;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycles;
  logic        dut_start;
  logic        dut_halt = 1'b0;
  logic        mem_own;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [7:0]  res_data;

  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 CLK = ~CLK;

  run_ctrl #(
    .AW(8),
    .DW(8),
    .START_CYCLES(SC),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .go(go),
    .rd_base(rd_base),
    .rd_len(rd_len),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycles(cycles),
    .dut_start(dut_start),
    .dut_halt(dut_halt),
    .mem_own(mem_own),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data)
  );

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    int          halt_at;   // RUN cycle at which halt rises, -1 = never
    int          rmode;     // 0 always ready, 1 toggle 1,0,1.., 2 random
    logic [15:0] exp_cycles;
    logic        exp_to;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_timeout"},   32'(timeout),   32'd0);
    chk({tag, "_cycles"},    32'(cycles),    32'd0);
    chk({tag, "_dut_start"}, 32'(dut_start), 32'd0);
    chk({tag, "_mem_own"},   32'(mem_own),   32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
  endtask

  // Reference: a run reports the RUN cycle at which halt arrived, unless
  // the watchdog (when present) expires first.
  function automatic logic [15:0] model_cycles(input int halt_at);
    if (TO_EN && (halt_at < 0 || halt_at >= int'(TB_TIMEOUT)))
      return TB_TIMEOUT;
    return 16'(halt_at);
  endfunction

  function automatic logic model_timeout(input int halt_at);
    return TO_EN && (halt_at < 0 || halt_at >= int'(TB_TIMEOUT));
  endfunction

  // One full run starting from IDLE, checking every cycle of it.
  task automatic run_once(input logic [7:0] base, input logic [8:0] len,
                          input int halt_at, input int rmode,
                          input logic [15:0] exp_cyc, input logic exp_to);
    int k;
    int idx;
    int budget;
    int steps;
    bit tog;
    bit rdy;
    logic [7:0] a;

    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_dut_start", 32'(dut_start), 32'd0);
    rd_base   = base;
    rd_len    = len;
    go        = 1'b1;
    dut_halt  = 1'b0;
    res_ready = 1'b0;
    tick();
    go = 1'b0;
    chk("go_clears_cycles", 32'(cycles), 32'd0);
    chk("go_clears_timeout", 32'(timeout), 32'd0);
    for (int s = 1; s <= SC; s++) begin
      chk("start_pulse", 32'(dut_start), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      dut_halt = 1'($urandom_range(0, 1));
      tick();
    end
    chk("start_end", 32'(dut_start), 32'd0);

    // RUN: k is the RUN cycle index of the cycle currently being driven.
    k = 0;
    budget = (halt_at >= 0 ? halt_at : 0) + int'(TB_TIMEOUT) + 5;
    forever begin
      dut_halt = (halt_at >= 0 && k >= halt_at);
      tick();
      k++;
      if (res_valid || done) break;
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_timeout_low", 32'(timeout), 32'd0);
      if (k > budget) begin
        chk("run_bound_expired", 32'(k), 32'(budget));
        dut_halt = 1'b0;
        return;
      end
    end
    if (!model_timeout(halt_at))
      chk("halt_latency", 32'(k), 32'(halt_at + 1));
    else
      chk("watchdog_by_limit", 32'(k <= int'(TB_TIMEOUT) + 1), 32'd1);
    chk("len0_no_valid", 32'(res_valid), 32'(len != 9'd0));
    chk("len0_done", 32'(done), 32'(len == 9'd0));

    // DRAIN
    idx = 0;
    tog = 1'b1;
    steps = 0;
    while (idx < int'(len)) begin
      a = base + 8'(idx);
      chk("drain_valid", 32'(res_valid), 32'd1);
      chk("drain_own", 32'(mem_own), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'(a));
      chk("drain_data", 32'(res_data), 32'(mem[a]));
      chk("drain_no_done", 32'(done), 32'd0);
      case (rmode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = !tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      res_ready = rdy;
      tick();
      if (rdy) idx++;
      steps++;
      if (steps > 4 * int'(len) + 10) begin
        chk("drain_bound_expired", 32'(idx), 32'(len));
        res_ready = 1'b0;
        return;
      end
    end
    res_ready = 1'($urandom_range(0, 1));
    dut_halt  = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_valid_low", 32'(res_valid), 32'd0);
    chk("done_own_low", 32'(mem_own), 32'd0);
    chk("cycles", 32'(cycles), 32'(exp_cyc));
    chk("timeout", 32'(timeout), 32'(exp_to));
    tick();
    res_ready = 1'b0;
    chk("done_single", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    chk("cycles_held", 32'(cycles), 32'(exp_cyc));
    chk("timeout_held", 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h00] = 8'h33;
    mem[8'h01] = 8'h44;

    vecs[0] = '{base: 8'h10, len: 9'd0, halt_at: 37, rmode: 0, exp_cycles: 16'd37, exp_to: 1'b0};
    vecs[1] = '{base: 8'hFE, len: 9'd4, halt_at: 5,  rmode: 1, exp_cycles: 16'd5,  exp_to: 1'b0};
    vecs[2] = '{base: 8'h20, len: 9'd3, halt_at: 0,  rmode: 0, exp_cycles: 16'd0,  exp_to: 1'b0};
`ifdef RUN_CTRL_TIMEOUT_EN
    vecs[3] = '{base: 8'h30, len: 9'd2, halt_at: -1, rmode: 0, exp_cycles: 16'd100, exp_to: 1'b1};
`else
    vecs[3] = '{base: 8'h30, len: 9'd2, halt_at: 10000, rmode: 0, exp_cycles: 16'd10000, exp_to: 1'b0};
`endif
    vecs[4] = '{base: 8'h80, len: 9'h100, halt_at: 2, rmode: 2, exp_cycles: 16'd2, exp_to: 1'b0};

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 5; i++)
      run_once(vecs[i].base, vecs[i].len, vecs[i].halt_at, vecs[i].rmode,
               vecs[i].exp_cycles, vecs[i].exp_to);

    // Reset mid-readback after two of four words
    rd_base = 8'h40; rd_len = 9'd4; go = 1'b1; dut_halt = 1'b0; res_ready = 1'b0;
    tick();
    go = 1'b0;
    tick();
    tick();
    dut_halt = 1'b1;
    tick();
    chk("mid_first_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    tick();
    chk("mid_third_addr", 32'(mem_addr), 32'h42);
    reset = 1'b1;
    res_ready = 1'b0;
    tick();
    reset = 1'b0;
    dut_halt = 1'b0;
    chk_reset_vals("mid_reset");
    tick();
    run_once(8'h50, 9'd2, 7, 0, 16'd7, 1'b0);

    // go held high through a whole run
    rd_base = 8'h00; rd_len = 9'd0; go = 1'b1; dut_halt = 1'b0;
    tick();
    chk("held_start", 32'(dut_start), 32'd1);
    tick();
    tick();
    for (int k = 0; k < 5; k++) tick();
    dut_halt = 1'b1;
    tick();
    chk("held_done", 32'(done), 32'd1);
    chk("held_cycles", 32'(cycles), 32'd5);
    tick();
    chk("held_idle", 32'(busy), 32'd0);
    chk("held_idle_done", 32'(done), 32'd0);
    tick();
    chk("held_restart", 32'(dut_start), 32'd1);
    chk("held_restart_clear", 32'(cycles), 32'd0);
    go = 1'b0;
    tick();
    tick();
    tick();
    chk("halt_first_done", 32'(done), 32'd1);
    chk("halt_first_cycles", 32'(cycles), 32'd0);
    dut_halt = 1'b0;
    tick();

    // Randomized runs against the model
    for (int r = 0; r < 20; r++) begin
      logic [7:0] b;
      logic [8:0] l;
      int h;
      b = 8'($urandom);
      l = 9'($urandom_range(0, 12));
      h = int'($urandom_range(0, 60));
      run_once(b, l, h, 2, model_cycles(h), model_timeout(h));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Host-side run sequencer for the basic processor. It is the driving end of the processor's `start`/`halt` handshake: on a `go` request it pulses the processor's `start`, then counts cycles until `halt` rises. A watchdog bounds that wait. It then reads a block of data memory back out through a valid/ready result stream and reports the cycle count. It sits between the bench or host and the processor top level, and owns the data-memory address port only while draining results.

## Interface
- `AW`, 8: data-memory address width.
- `DW`, 8: data-memory word width.
- `START_CYCLES`, 2: length of the `dut_start` pulse in cycles; must be ≥1.
- `TIMEOUT`, 16'd50000: RUN cycles allowed before the watchdog fires.

Ports (single clock domain; reset is synchronous and active-high):
- `CLK` in 1: clock; posedge used.
- `reset` in 1: synchronous, active-high reset.
- `go` in 1: run request; sampled only in IDLE.
- `rd_base` in AW: first readback address, captured on `go`.
- `rd_len` in AW+1: number of words to read back (0..2^AW), captured on `go`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of run.
- `timeout` out 1: sticky watchdog flag for last run.
- `cycles` out 16: cycle count of last run, saturating.
- `dut_start` out 1: drives processor `start`.
- `dut_halt` in 1: processor `halt`.
- `mem_own` out 1: high when this block drives the data-memory address.
- `mem_addr` out AW: data-memory address.
- `mem_rdata` in DW: data-memory read data, combinational on `mem_addr`.
- `res_valid` out 1: readback word available.
- `res_ready` in 1: consumer accepts word.
- `res_data` out DW: readback word; equals `mem_rdata`.

## Operation
- States: IDLE, START, RUN, DRAIN, DONE.
- **IDLE**
  - `go`=1: capture `rd_base`/`rd_len`, clear `cycles` and `timeout`, go to START.
- **START**
  - `dut_start`=1 for exactly START_CYCLES cycles, then go to RUN.
  - `dut_halt` is ignored here.
- **RUN**
  - Each cycle with `dut_halt`=0: increment the run counter; `cycles` saturates at 16'hFFFF.
  - `dut_halt`=1: latch the count into `cycles`, go to DRAIN. If halt is high in the first RUN cycle, `cycles`=0.
  - If the count reaches TIMEOUT with halt still low: set `timeout`=1, `cycles`=TIMEOUT, go to DRAIN. Readback still occurs.
- **DRAIN**
  - `mem_own`=1, `res_valid`=1, `mem_addr` = `rd_base`+idx, computed mod 2^AW so it wraps.
  - Each cycle with `res_valid` && `res_ready`: idx++.
  - After word `rd_len`−1 is accepted: go to DONE.
  - `rd_len`=0: DRAIN is entered for zero cycles; go straight to DONE.
  - While `res_ready`=0, `mem_addr` and `res_data` are held stable.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- `go` outside IDLE is ignored. `cycles` and `timeout` hold until the next accepted `go`.

## Timing
- Reset values: state=IDLE; `busy`=0, `done`=0, `timeout`=0, `cycles`=0, `dut_start`=0, `mem_own`=0, `mem_addr`=0, `res_valid`=0.
- All outputs are registered except `res_data`, which is combinational from `mem_rdata`.
- `go` at cycle T:
  - `busy`=1 and `dut_start`=1 from T+1 through T+START_CYCLES.
  - RUN begins at T+START_CYCLES+1.
- Halt seen in RUN cycle N (N counted from 0): `cycles`=N, and `res_valid` rises the next cycle.
- `done` pulses the cycle after the last accepted result word. `busy` falls together with `done`.
- Reset asserted in any state: next cycle is IDLE with all reset values. `dut_start` is dropped immediately, and any in-flight result is abandoned (`res_valid`=0).
- `res_valid` is never withdrawn without a handshake, except by reset.

## Configuration
- `RUN_CTRL_TIMEOUT_EN`
  - Defined: watchdog compiled in as described.
  - Undefined: RUN waits indefinitely for `dut_halt`, `timeout` is tied 0, and the TIMEOUT parameter is unused.

## Test plan
- START_CYCLES=2; `go` at T; halt rises 37 cycles into RUN, rd_len=0 -> `dut_start` high exactly T+1..T+2; `cycles`=37; `done` pulses with no `res_valid` cycle.
- rd_base=8'hFE, rd_len=4, memory holds FE:11, FF:22, 00:33, 01:44, `res_ready` toggled 1,0,1,0… -> data 11,22,33,44 in order; `mem_addr` wraps FF→00; each word held while ready is 0.
- Halt high in the first RUN cycle -> `cycles`=0, readback proceeds normally.
- TIMEOUT=100, halt never rises -> `timeout`=1, `cycles`=100, readback still performed, `done` pulses. With `RUN_CTRL_TIMEOUT_EN` undefined -> `busy` stays 1 for 10000 cycles and `timeout`=0.
- `reset` pulsed mid-DRAIN after 2 of 4 words -> next cycle all outputs at reset values; a new `go` runs cleanly and clears `cycles`/`timeout`.
- `go` held high through a whole run -> a second run starts from IDLE immediately after `done`; `go` during RUN has no effect on the count.
